// File: rtl/camera_pkg.sv
// Shared constants for the camera windowing path: default widths and FSM
// state encodings used by camera_crop.
package camera_pkg;

    localparam int DATA_DEFAULT = 10;
    localparam int CW_DEFAULT   = 12;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;  // waiting for a frame start
    localparam state_t ST_SKIP   = 2'd1;  // frame rejected, wait for it to end
    localparam state_t ST_ACTIVE = 2'd2;  // frame accepted, window being passed
    localparam state_t ST_DONE   = 2'd3;  // window complete, wait for frame end

endpackage

// File: rtl/crop_pos_counter.sv
// Pixel (x) and line (y) position counters for the raw camera stream.
// x is the index of the current pixel within its line, y the index of the
// current line within its frame. Both saturate instead of wrapping so an
// oversized input can never alias back into the crop window.
module crop_pos_counter
    import camera_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          wr_clk,
    input  logic          rst_n,
    input  logic          fv_in,
    input  logic          lv_in,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          x_sat,
    output logic          fv_rise,
    output logic          lv_fall
);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          lv_prev_q, lv_prev_d;
    logic          fv_prev_q, fv_prev_d;
    logic          arm_q, arm_d;
    logic          lv_act;

    // Next-state of counters and edge detectors.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        lv_act    = fv_in & lv_in;
        lv_fall   = lv_prev_q & ~lv_act;
        // arm_q blocks a "rising edge" on the first cycle out of reset, so a
        // frame already in progress at reset release is never taken.
        fv_rise   = fv_in & ~fv_prev_q & arm_q;
        lv_prev_d = lv_act;
        fv_prev_d = fv_in;
        arm_d     = 1'b1;

        x_d = '0;
        if (lv_act) begin
            x_d = (&x_q) ? x_q : x_q + 1'b1;
        end

        y_d = y_q;
        if (!fv_in) begin
            y_d = '0;
        end else if (lv_fall && !(&y_q)) begin
            y_d = y_q + 1'b1;
        end
    end

    // Position and edge-detect registers, synchronous reset.
    always_ff @(posedge wr_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            lv_prev_q <= 1'b0;
            fv_prev_q <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            lv_prev_q <= lv_prev_d;
            fv_prev_q <= fv_prev_d;
            arm_q     <= arm_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign x_sat = &x_q;

endmodule

// File: rtl/camera_crop.sv
// Crop window between the camera pixel interface and frame_buffer. Passes
// only [X0,X0+WIDTH) x [Y0,Y0+HEIGHT) of each accepted frame, with all
// outputs registered (one cycle latency), and flags short lines/frames.
module camera_crop
    import camera_pkg::*;
#(
    parameter int DATA   = DATA_DEFAULT,
    parameter int CW     = CW_DEFAULT,
    parameter int X0     = 0,
    parameter int WIDTH  = 1280,
    parameter int Y0     = 0,
    parameter int HEIGHT = 2
) (
    input  logic            wr_clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            fv_in,
    input  logic            lv_in,
    input  logic [DATA-1:0] pixel_in,
    output logic            fv_out,
    output logic            lv_out,
    output logic [DATA-1:0] pixel_out,
    output logic            frame_done,
    output logic            short_line,
    output logic            short_frame
);

    localparam int X_END  = X0 + WIDTH;
    localparam int Y_END  = Y0 + HEIGHT;
    localparam int Y_LAST = Y_END - 1;

    logic [CW-1:0] x, y;
    logic          x_sat, fv_rise, lv_fall;

    crop_pos_counter #(.CW(CW)) u_pos (
        .wr_clk  (wr_clk),
        .rst_n   (rst_n),
        .fv_in   (fv_in),
        .lv_in   (lv_in),
        .x       (x),
        .y       (y),
        .x_sat   (x_sat),
        .fv_rise (fv_rise),
        .lv_fall (lv_fall)
    );

    state_t          state_q, state_d;
    logic            fv_out_q, fv_out_d;
    logic            lv_out_q, lv_out_d;
    logic [DATA-1:0] pixel_out_q, pixel_out_d;
    logic            frame_done_q, frame_done_d;
    logic            short_line_q, short_line_d;
    logic            short_frame_q, short_frame_d;

    logic x_in_win, y_in_win, pass, last_line_end, line_short;

    // Window compare. A saturated x stands for "some pixel at or beyond the
    // counter limit", so it is treated as outside the window.
    always_comb begin
        x_in_win      = !x_sat && (int'(x) >= X0) && (int'(x) < X_END);
        y_in_win      = (int'(y) >= Y0) && (int'(y) < Y_END);
        pass          = fv_in && lv_in && x_in_win && y_in_win;
        last_line_end = lv_fall && (int'(y) == Y_LAST);
        line_short    = lv_fall && y_in_win && (int'(x) < X_END);
    end

    // Frame FSM and next values of the registered outputs.
    always_comb begin
        state_d       = state_q;
        fv_out_d      = 1'b0;
        lv_out_d      = 1'b0;
        pixel_out_d   = pixel_out_q;
        frame_done_d  = 1'b0;
        short_line_d  = short_line_q;
        short_frame_d = short_frame_q;

        case (state_q)
            ST_IDLE: begin
                if (fv_rise && en) begin
                    state_d       = ST_ACTIVE;
                    fv_out_d      = 1'b1;
                    short_line_d  = 1'b0;
                    short_frame_d = 1'b0;
                end else if (fv_in) begin
                    // Disabled at frame start, or frame already running.
                    state_d = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (!fv_in) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                fv_out_d = fv_in;
                lv_out_d = pass;
                if (pass) begin
                    pixel_out_d = pixel_in;
                end
                if (line_short) begin
                    short_line_d = 1'b1;
                end
                if (!fv_in) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    // A frame that ends together with its last window line
                    // is complete; anything earlier is short.
                    if (!last_line_end) begin
                        short_frame_d = 1'b1;
                    end
                end else if (last_line_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fv_out_d = fv_in;
                if (!fv_in) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fv_out_q      <= 1'b0;
            lv_out_q      <= 1'b0;
            pixel_out_q   <= '0;
            frame_done_q  <= 1'b0;
            short_line_q  <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fv_out_q      <= fv_out_d;
            lv_out_q      <= lv_out_d;
            pixel_out_q   <= pixel_out_d;
            frame_done_q  <= frame_done_d;
            short_line_q  <= short_line_d;
            short_frame_q <= short_frame_d;
        end
    end

    assign fv_out      = fv_out_q;
    assign lv_out      = lv_out_q;
    assign pixel_out   = pixel_out_q;
    assign frame_done  = frame_done_q;
    assign short_line  = short_line_q;
    assign short_frame = short_frame_q;

endmodule
